// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register: owns the PC, fetches over a single-outstanding
// req/ack handshake, and applies the ID-stage redirect (flush) and stall.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP      = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic              stall_ID,
    input  logic              pcSrc_IF,
    input  logic [ADDR_W-1:0] branchTarget_ID,
    output logic [31:0]       instr_ID,
    output logic [ADDR_W-1:0] pcPlus4_ID,
    output logic              valid_ID,
    output logic [1:0]        dbgState
);

    // Handshake: imem_req/imem_addr are held stable from the cycle a request is raised
    // until the rising edge at which imem_ack=1 is sampled; that edge completes it and
    // imem_rdata is only looked at on that edge. Acks with no request raised are ignored.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetchState_e;

    fetchState_e       state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [ADDR_W-1:0] tgt, tgtNext;
    logic [31:0]       bufWord, bufNext;
    logic [31:0]       instrNext;
    logic [ADDR_W-1:0] pcPlus4Next;
    logic              validNext;

    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] target;
    logic              accept;
    logic [31:0]       acceptWord;

    // Modulo 2^ADDR_W by construction; redirect targets are forced word aligned.
    assign pcPlus4 = pc + ADDR_W'(4);
    assign target  = branchTarget_ID & ~ADDR_W'(3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  stateNext = S_REQ;
            S_REQ: begin
                if (pcSrc_IF && !imem_ack) begin
                    stateNext = S_DRAIN;
                end else if (!pcSrc_IF && imem_ack && stall_ID) begin
                    stateNext = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pcSrc_IF || !stall_ID) begin
                    stateNext = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    stateNext = S_REQ;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = (state == S_REQ) || (state == S_DRAIN);
        imem_addr = pc;
        dbgState  = state;
    end

    // PC, redirect target, skid buffer and accepted-word selection
    always_comb begin
        pcNext     = pc;
        tgtNext    = tgt;
        bufNext    = bufWord;
        accept     = 1'b0;
        acceptWord = NOP;
        case (state)
            S_REQ: begin
                if (pcSrc_IF) begin
                    if (imem_ack) begin
                        pcNext = target;
                    end else begin
                        tgtNext = target;
                    end
                end else if (imem_ack) begin
                    if (stall_ID) begin
                        bufNext = imem_rdata;
                    end else begin
                        accept     = 1'b1;
                        acceptWord = imem_rdata;
                        pcNext     = pcPlus4;
                    end
                end
            end
            S_HOLD: begin
                if (pcSrc_IF) begin
                    pcNext = target;
                end else if (!stall_ID) begin
                    accept     = 1'b1;
                    acceptWord = bufWord;
                    pcNext     = pcPlus4;
                end
            end
            S_DRAIN: begin
                // A redirect arriving together with the ack is the youngest one and wins.
                if (pcSrc_IF) begin
                    tgtNext = target;
                end
                if (imem_ack) begin
                    pcNext = pcSrc_IF ? target : tgt;
                end
            end
            default: ;
        endcase
    end

    // IF/ID next value: flush beats stall, stall beats load, nothing accepted is a bubble
    always_comb begin
        instrNext   = instr_ID;
        pcPlus4Next = pcPlus4_ID;
        validNext   = valid_ID;
        if (pcSrc_IF) begin
            instrNext   = NOP;
            pcPlus4Next = '0;
            validNext   = 1'b0;
        end else if (!stall_ID) begin
            if (accept) begin
                instrNext   = acceptWord;
                pcPlus4Next = pcPlus4;
                validNext   = 1'b1;
            end else begin
                instrNext   = NOP;
                pcPlus4Next = '0;
                validNext   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            tgt        <= RESET_PC;
            bufWord    <= NOP;
            instr_ID   <= NOP;
            pcPlus4_ID <= '0;
            valid_ID   <= 1'b0;
        end else begin
            pc         <= pcNext;
            tgt        <= tgtNext;
            bufWord    <= bufNext;
            instr_ID   <= instrNext;
            pcPlus4_ID <= pcPlus4Next;
            valid_ID   <= validNext;
        end
    end

endmodule
